// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source and stall-bus bundle between pipeline control and the
// hazard unit. The pipeline drives the master side.
interface pipe_hazard_ctrl_if #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              ex_valid;
    logic              ex_load;
    logic [4:0]        ex_waddr;
    logic              mdu_start;
    logic              mdu_is_div;
    logic              sram_wait;
    logic              cnt_clr;
    logic [STAGES:0]   stall;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              mdu_busy;
    logic              mdu_done;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used,
        output ex_valid, ex_load, ex_waddr,
        output mdu_start, mdu_is_div, sram_wait, cnt_clr,
        input  stall, stallreq_id, stallreq_ex,
        input  mdu_busy, mdu_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used,
        input  ex_valid, ex_load, ex_waddr,
        input  mdu_start, mdu_is_div, sram_wait, cnt_clr,
        output stall, stallreq_id, stallreq_ex,
        output mdu_busy, mdu_done, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall controller: load-use, multi-cycle mul/div and SRAM wait
// folded into a per-stage hold bus, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int STAGES   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int SW      = STAGES + 1;
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MW      = $clog2(MAX_LAT + 1);
    localparam logic [MW-1:0] MUL_LD = MW'(MUL_LAT - 1);
    localparam logic [MW-1:0] DIV_LD = MW'(DIV_LAT - 1);
    localparam logic [SW-1:0] HOLD_ID  = SW'(3'b111);
    localparam logic [SW-1:0] HOLD_EX  = SW'(4'b1111);
    localparam logic [SW-1:0] HOLD_MEM = SW'(5'b11111);

    logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [SW-1:0]    stall;
    logic             hit_rs_pl, hit_rt_pl;
    logic             haz_rs, haz_rt;
    logic             req_id, req_ex;
    logic             busy, accept, done, ex_ld;

    assign ex_ld  = bus.ex_valid & bus.ex_load;
    assign busy   = mdu_cnt_q != '0;
    assign accept = bus.mdu_start & bus.ex_valid & ~busy;
    assign req_ex = busy | accept;

    assign haz_rs = bus.id_rs_used & (bus.id_rs != 5'd0)
                  & ((ex_ld & (bus.id_rs == bus.ex_waddr)) | hit_rs_pl);
    assign haz_rt = bus.id_rt_used & (bus.id_rt != 5'd0)
                  & ((ex_ld & (bus.id_rt == bus.ex_waddr)) | hit_rt_pl);
    assign req_id = haz_rs | haz_rt;

    // Counter holds LAT-1 so the hold ends exactly LAT cycles after the start.
    assign done = accept
                ? (bus.mdu_is_div ? (DIV_LAT == 1) : (MUL_LAT == 1))
                : (mdu_cnt_q == MW'(1));

    always_comb begin
        stall = '0;
        if (bus.sram_wait)
            stall = HOLD_MEM;
        else if (req_ex)
            stall = HOLD_EX;
        else if (req_id)
            stall = HOLD_ID;
    end

    generate
        if (LOAD_LAT > 1) begin : g_pl
            localparam int PL_N = LOAD_LAT - 1;
            logic [PL_N-1:0]      pl_v_q, pl_v_d;
            logic [PL_N-1:0][4:0] pl_a_q, pl_a_d;

            always_comb begin
                pl_v_d = pl_v_q;
                pl_a_d = pl_a_q;
                if (!stall[4]) begin
                    for (int i = PL_N - 1; i > 0; i--) begin
                        pl_v_d[i] = pl_v_q[i-1];
                        pl_a_d[i] = pl_a_q[i-1];
                    end
                    pl_v_d[0] = ex_ld & ~stall[3];
                    pl_a_d[0] = bus.ex_waddr;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pl_v_q <= '0;
                    pl_a_q <= '0;
                end else begin
                    pl_v_q <= pl_v_d;
                    pl_a_q <= pl_a_d;
                end
            end

            always_comb begin
                hit_rs_pl = 1'b0;
                hit_rt_pl = 1'b0;
                for (int i = 0; i < PL_N; i++) begin
                    hit_rs_pl |= pl_v_q[i] & (pl_a_q[i] == bus.id_rs);
                    hit_rt_pl |= pl_v_q[i] & (pl_a_q[i] == bus.id_rt);
                end
            end
        end else begin : g_no_pl
            assign hit_rs_pl = 1'b0;
            assign hit_rt_pl = 1'b0;
        end
    endgenerate

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (accept)
            mdu_cnt_d = bus.mdu_is_div ? DIV_LD : MUL_LD;
        else if (busy)
            mdu_cnt_d = mdu_cnt_q - 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr)
            stall_cnt_d = '0;
        else if (stall[0] && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign bus.stall       = rst ? stall : '0;
    assign bus.stallreq_id = rst & req_id;
    assign bus.stallreq_ex = rst & req_ex;
    assign bus.mdu_done    = rst & done;
    assign bus.mdu_busy    = busy;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations driven in parallel and
// checked against a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_waddr;
    logic       id_rs_used, id_rt_used, ex_valid, ex_load;
    logic       mdu_start, mdu_is_div, sram_wait, cnt_clr;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl_if #(.STAGES(5), .CNT_W(32)) ifa ();
    pipe_hazard_ctrl_if #(.STAGES(5), .CNT_W(4))  ifb ();

    assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
    assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
    assign ifa.id_rs_used = id_rs_used; assign ifb.id_rs_used = id_rs_used;
    assign ifa.id_rt_used = id_rt_used; assign ifb.id_rt_used = id_rt_used;
    assign ifa.ex_valid = ex_valid;     assign ifb.ex_valid = ex_valid;
    assign ifa.ex_load = ex_load;       assign ifb.ex_load = ex_load;
    assign ifa.ex_waddr = ex_waddr;     assign ifb.ex_waddr = ex_waddr;
    assign ifa.mdu_start = mdu_start;   assign ifb.mdu_start = mdu_start;
    assign ifa.mdu_is_div = mdu_is_div; assign ifb.mdu_is_div = mdu_is_div;
    assign ifa.sram_wait = sram_wait;   assign ifb.sram_wait = sram_wait;
    assign ifa.cnt_clr = cnt_clr;       assign ifb.cnt_clr = cnt_clr;

    pipe_hazard_ctrl #(
        .STAGES(5), .LOAD_LAT(1), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(32)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    pipe_hazard_ctrl #(
        .STAGES(5), .LOAD_LAT(3), .MUL_LAT(1), .DIV_LAT(5), .CNT_W(4)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference model: in-flight loads as queues of dest regs (-1 = bubble),
    // mul/div ops as [start, last-hold] cycle windows.
    int     cyc = 0;
    int     pqa[$];
    int     pqb[$];
    int     mst[2]  = '{-1, -1};
    int     mend[2] = '{-1, -1};
    longint cnt[2]  = '{0, 0};

    function automatic int mlat(int i, logic dv);
        if (i == 0) return dv ? 32 : 4;
        return dv ? 5 : 1;
    endfunction

    function automatic longint cmax(int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    function automatic bit m_busy(int i);
        return cyc > mst[i] && cyc <= mend[i];
    endfunction

    function automatic bit m_acc(int i);
        return mdu_start && ex_valid && !m_busy(i);
    endfunction

    function automatic bit in_pend(int i, logic [4:0] r);
        int q[$];
        if (i == 0) q = pqa;
        else q = pqb;
        foreach (q[j]) if (q[j] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit src_hz(int i, logic u, logic [4:0] r);
        if (!u || r == 5'd0) return 1'b0;
        return (ex_valid && ex_load && r == ex_waddr) || in_pend(i, r);
    endfunction

    function automatic bit e_id(int i);
        return rst && (src_hz(i, id_rs_used, id_rs) || src_hz(i, id_rt_used, id_rt));
    endfunction

    function automatic bit e_ex(int i);
        return rst && (m_busy(i) || m_acc(i));
    endfunction

    function automatic bit e_done(int i);
        if (!rst) return 1'b0;
        if (m_acc(i)) return mlat(i, mdu_is_div) == 1;
        return m_busy(i) && cyc == mend[i];
    endfunction

    function automatic logic [5:0] e_stall(int i);
        int k;
        if (!rst) return 6'd0;
        k = sram_wait ? 4 : e_ex(i) ? 3 : e_id(i) ? 2 : -1;
        if (k < 0) return 6'd0;
        return 6'((1 << (k + 1)) - 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pqa.delete();
            pqb.delete();
            mst  = '{-1, -1};
            mend = '{-1, -1};
            cnt  = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [5:0] s;
                bit         a;
                int         v;
                s = e_stall(i);
                a = m_acc(i);
                if (!s[4]) begin
                    v = (!s[3] && ex_valid && ex_load) ? int'(ex_waddr) : -1;
                    if (i == 0) begin
                        pqa.push_front(v);
                        if (pqa.size() > 0) void'(pqa.pop_back());
                    end else begin
                        pqb.push_front(v);
                        if (pqb.size() > 2) void'(pqb.pop_back());
                    end
                end
                if (a) begin
                    mst[i]  = cyc;
                    mend[i] = cyc + mlat(i, mdu_is_div) - 1;
                end
                if (cnt_clr) cnt[i] = 0;
                else if (s[0] && cnt[i] < cmax(i)) cnt[i] = cnt[i] + 1;
            end
            cyc++;
        end
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        ex_valid = 0; ex_load = 0; ex_waddr = 0;
        mdu_start = 0; mdu_is_div = 0; sram_wait = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sram_wait = 1; ex_valid = 1; mdu_start = 1;
        @(negedge clk); #1;
        total++;
        if (ifa.stall !== 6'd0 || ifb.stall !== 6'd0) begin
            bad++;
            $display("FAIL reset_stall got a=%b b=%b want 000000", ifa.stall, ifb.stall);
        end
        total++;
        if (ifa.stall_cnt !== 32'd0 || ifa.mdu_busy !== 1'b0 || ifa.stallreq_ex !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d busy=%b ex=%b want 0 0 0",
                     ifa.stall_cnt, ifa.mdu_busy, ifa.stallreq_ex);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        int n;
        idle();
        @(negedge clk);
        ex_valid = 1; ex_load = 1; ex_waddr = 2;
        id_rs = 2; id_rs_used = 1; id_rt = 4; id_rt_used = 1;
        #1;
        total++;
        if (ifa.stallreq_id !== 1'b1 || ifa.stall !== 6'b000111) begin
            bad++;
            $display("FAIL lu_hit_a got id=%b stall=%b want 1 000111", ifa.stallreq_id, ifa.stall);
        end
        @(negedge clk);
        ex_valid = 0; ex_load = 0;
        #1;
        total++;
        if (ifa.stall !== 6'd0 || ifa.stallreq_id !== 1'b0) begin
            bad++;
            $display("FAIL lu_release_a got stall=%b id=%b want 000000 0", ifa.stall, ifa.stallreq_id);
        end
        n = 1;
        while (ifb.stall == 6'b000111 && n < 10) begin
            n++;
            @(negedge clk); #1;
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL lu_lat3_b got %0d stall cycles want 3", n);
        end
        idle();
        @(negedge clk);
        ex_valid = 1; ex_load = 1; ex_waddr = 0;
        id_rs_used = 1; id_rt_used = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (ifa.stall !== 6'd0 || ifb.stall !== 6'd0) begin
                bad++;
                $display("FAIL lu_r0 got a=%b b=%b want 000000", ifa.stall, ifb.stall);
            end
            @(negedge clk);
        end
        idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_div();
        logic [5:0] es;
        bit eb, ed;
        idle();
        @(negedge clk);
        ex_valid = 1; mdu_start = 1; mdu_is_div = 1;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) begin
                @(negedge clk);
                mdu_start = 0;
            end
            #1;
            es = (c <= 32) ? 6'b001111 : 6'b000000;
            eb = (c >= 2 && c <= 32);
            ed = (c == 32);
            total++;
            if (ifa.stall !== es || ifa.mdu_busy !== eb || ifa.mdu_done !== ed) begin
                bad++;
                $display("FAIL div_c%0d got stall=%b busy=%b done=%b want %b %b %b",
                         c, ifa.stall, ifa.mdu_busy, ifa.mdu_done, es, eb, ed);
            end
        end
    endtask

    task automatic test_div_sram();
        logic [5:0] es;
        bit ed;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            ex_valid   = 1;
            mdu_start  = (c == 1 || c == 10);
            mdu_is_div = (c == 1);
            sram_wait  = (c >= 5 && c <= 7);
            #1;
            es = (c >= 5 && c <= 7) ? 6'b011111 :
                 (c <= 32) ? 6'b001111 : 6'b000000;
            ed = (c == 32);
            total++;
            if (ifa.stall !== es || ifa.mdu_done !== ed) begin
                bad++;
                $display("FAIL divsram_c%0d got stall=%b done=%b want %b %b",
                         c, ifa.stall, ifa.mdu_done, es, ed);
            end
        end
        idle();
    endtask

    task automatic test_sat();
        idle();
        @(negedge clk);
        cnt_clr = 1;
        @(negedge clk);
        cnt_clr = 0; sram_wait = 1;
        repeat (14) @(negedge clk);
        #1;
        total++;
        if (ifb.stall_cnt !== 4'd14) begin
            bad++;
            $display("FAIL sat_pre got %0d want 14", ifb.stall_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (ifb.stall_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_top got %0d want 15", ifb.stall_cnt);
        end
        total++;
        if (ifa.stall_cnt !== 32'(cnt[0])) begin
            bad++;
            $display("FAIL sat_cnt_a got %0d want %0d", ifa.stall_cnt, cnt[0]);
        end
        @(negedge clk);
        cnt_clr = 1;
        @(negedge clk);
        #1;
        total++;
        if (ifb.stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL sat_clr got %0d want 0", ifb.stall_cnt);
        end
        idle();
    endtask

    task automatic test_reset_mid_div();
        bit ee, eb, ed;
        idle();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            ex_valid = 1;
            mdu_start = (c == 1); mdu_is_div = 1;
            sram_wait = (c == 10);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (ifa.mdu_busy !== 1'b0 || ifa.stall !== 6'd0 || ifa.stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid got busy=%b stall=%b cnt=%0d want 0 000000 0",
                     ifa.mdu_busy, ifa.stall, ifa.stall_cnt);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ex_valid = 1; mdu_start = (c == 1); mdu_is_div = 0;
            #1;
            ee = (c <= 4);
            eb = (c >= 2 && c <= 4);
            ed = (c == 4);
            total++;
            if (ifa.stallreq_ex !== ee || ifa.mdu_busy !== eb || ifa.mdu_done !== ed) begin
                bad++;
                $display("FAIL rst_mul_c%0d got ex=%b busy=%b done=%b want %b %b %b",
                         c, ifa.stallreq_ex, ifa.mdu_busy, ifa.mdu_done, ee, eb, ed);
            end
        end
        idle();
    endtask

    task automatic test_random();
        repeat (600) begin
            @(negedge clk);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            ex_waddr   = 5'($urandom_range(0, 7));
            id_rs_used = 1'($urandom_range(0, 1));
            id_rt_used = 1'($urandom_range(0, 1));
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_load    = 1'($urandom_range(0, 1));
            mdu_start  = ($urandom_range(0, 9) == 0);
            mdu_is_div = ($urandom_range(0, 3) == 0);
            sram_wait  = ($urandom_range(0, 7) == 0);
            cnt_clr    = ($urandom_range(0, 63) == 0);
            #1;
            total++;
            if (ifa.stall !== e_stall(0) || ifa.stallreq_id !== e_id(0) ||
                ifa.stallreq_ex !== e_ex(0) || ifa.mdu_busy !== m_busy(0) ||
                ifa.mdu_done !== e_done(0) || ifa.stall_cnt !== 32'(cnt[0])) begin
                bad++;
                $display("FAIL rand_a cyc=%0d got %b %b %b %b %b %0d want %b %b %b %b %b %0d",
                         cyc, ifa.stall, ifa.stallreq_id, ifa.stallreq_ex, ifa.mdu_busy,
                         ifa.mdu_done, ifa.stall_cnt, e_stall(0), e_id(0), e_ex(0),
                         m_busy(0), e_done(0), cnt[0]);
            end
            total++;
            if (ifb.stall !== e_stall(1) || ifb.stallreq_id !== e_id(1) ||
                ifb.stallreq_ex !== e_ex(1) || ifb.mdu_busy !== m_busy(1) ||
                ifb.mdu_done !== e_done(1) || ifb.stall_cnt !== 4'(cnt[1])) begin
                bad++;
                $display("FAIL rand_b cyc=%0d got %b %b %b %b %b %0d want %b %b %b %b %b %0d",
                         cyc, ifb.stall, ifb.stallreq_id, ifb.stallreq_ex, ifb.mdu_busy,
                         ifb.mdu_done, ifb.stall_cnt, e_stall(1), e_id(1), e_ex(1),
                         m_busy(1), e_done(1), cnt[1]);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_div();
        test_div_sram();
        test_sat();
        test_reset_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
